// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter with run/done sequencing, branches and a call/return stack
module fetch_sequencer #(
    parameter int D          = 12,
    parameter int OW         = 6,
    parameter int DEPTH      = 4,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic [1:0]    branch,
    input  logic          jcnd,
    input  logic [D-1:0]  target,
    input  logic [OW-1:0] offset,
    input  logic          call,
    input  logic          ret,
    input  logic          halt,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic          stk_err
);
    localparam int SW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [SW-1:0] sp, sp_n;
    logic [D-1:0]  stack [2**SW];
    logic [D-1:0]  pc_n, pc_inc, pc_rel, pc_step;
    logic          done_n, err_n, push, pop_ok, push_ok, bad;

    assign pc_inc  = prog_ctr + D'(1);
    assign pc_rel  = prog_ctr + {{(D-OW){offset[OW-1]}}, offset};
    assign pop_ok  = ret && sp != '0;
    assign push_ok = call && !ret && sp < SW'(DEPTH);
    assign bad     = (ret && sp == '0) || (call && !ret && sp == SW'(DEPTH));
    assign running = state == RUN;

    // candidate next PC for an unstalled run step: ret > call > branch > increment
    always_comb begin
        pc_step = ret ? (pop_ok ? stack[sp - SW'(1)] : pc_inc) :
                  call ? target :
                  branch == 2'b01 ? target :
                  branch == 2'b10 ? (jcnd ? target : pc_inc) :
                  branch == 2'b11 ? (jcnd ? pc_rel : pc_inc) : pc_inc;
    end

    // sequencing: next state, PC, stack pointer and flags
    always_comb begin
        state_n = state;
        pc_n    = prog_ctr;
        sp_n    = sp;
        done_n  = done;
        err_n   = stk_err;
        push    = 1'b0;
        case (state)
            IDLE: begin
                pc_n   = D'(START_ADDR);
                done_n = 1'b0;
                if (req) begin
                    state_n = RUN;
                    sp_n    = '0;
                    err_n   = 1'b0;
                end
            end
            RUN: begin
                if (!stall && halt) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (!stall) begin
                    pc_n  = pc_step;
                    sp_n  = pop_ok ? sp - SW'(1) : push_ok ? sp + SW'(1) : sp;
                    err_n = stk_err | bad;
                    push  = push_ok;
                    if (pc_step == D'(END_ADDR)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!req) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                    pc_n    = D'(START_ADDR);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            prog_ctr <= D'(START_ADDR);
            sp       <= '0;
            done     <= 1'b0;
            stk_err  <= 1'b0;
        end else begin
            state    <= state_n;
            prog_ctr <= pc_n;
            sp       <= sp_n;
            done     <= done_n;
            stk_err  <= err_n;
        end
    end

    // return-address storage; contents need no reset since sp gates every read
    always_ff @(posedge clk) begin
        if (push) stack[sp] <= pc_inc;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench for fetch_sequencer against a queue-based model
module tb_fetch_sequencer;
    localparam int START = 0;
    localparam int ENDA  = 128;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, stall = 1'b0, jcnd = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0;
    logic [1:0]  branch = 2'b00;
    logic [11:0] target = '0;
    logic [5:0]  offset = '0;
    logic [11:0] prog_ctr;
    logic        running, done, stk_err;

    typedef struct packed {
        logic [11:0] pc;
        logic        run;
        logic        dn;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    int   m_mode = 0;
    int   m_pc = START;
    bit   m_err = 1'b0;
    int   ras[$];

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall), .branch(branch),
        .jcnd(jcnd), .target(target), .offset(offset), .call(call), .ret(ret),
        .halt(halt), .prog_ctr(prog_ctr), .running(running), .done(done),
        .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        int nxt;
        if (!reset) begin
            m_mode = 0;
            m_pc   = START;
            m_err  = 1'b0;
            ras.delete();
        end else if (m_mode == 0) begin
            m_pc = START;
            if (req) begin
                m_mode = 1;
                m_err  = 1'b0;
                ras.delete();
            end
        end else if (m_mode == 1 && !stall) begin
            if (halt) m_mode = 2;
            else begin
                nxt = m_pc + 1;
                if (ret) begin
                    if (ras.size() > 0) nxt = ras.pop_back();
                    else m_err = 1'b1;
                end else if (call) begin
                    if (ras.size() < DEPTH) ras.push_back((m_pc + 1) & 4095);
                    else m_err = 1'b1;
                    nxt = target;
                end else if (branch == 2'b01) nxt = target;
                else if (branch == 2'b10 && jcnd) nxt = target;
                else if (branch == 2'b11 && jcnd) nxt = m_pc + int'($signed(offset));
                m_pc = nxt & 4095;
                if (m_pc == ENDA) m_mode = 2;
            end
        end else if (m_mode == 2 && !req) begin
            m_mode = 0;
            m_pc   = START;
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e = '{pc: m_pc[11:0], run: m_mode == 1, dn: m_mode == 2, err: m_err};
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic drive(input logic rq, input logic st, input logic [1:0] br, input logic jc,
                         input logic [11:0] tg, input logic [5:0] of, input logic cl,
                         input logic rt, input logic hl);
        req = rq; stall = st; branch = br; jcnd = jc; target = tg; offset = of;
        call = cl; ret = rt; halt = hl;
        tick();
    endtask

    task automatic plain();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_pc", int'(prog_ctr), START);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_err", int'(stk_err), 0);
        tick();
        reset = 1'b1;
    endtask

    // monitor: every cycle the DUT presents a fetch address, compare it with the oldest expectation
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                a = '{pc: prog_ctr, run: running, dn: done, err: stk_err};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL scoreboard pc/run/done/err got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                             a.pc, a.run, a.dn, a.err, e.pc, e.run, e.dn, e.err);
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        reset = 1'b1;
        // reset in the middle of a run
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        repeat (37) plain();
        chk("pc_before_reset", int'(prog_ctr), 37);
        do_reset();
        plain();
        chk("run_after_reset", int'(running), 1);
        chk("pc_after_reset", int'(prog_ctr), 0);
        plain();
        chk("pc_first_step", int'(prog_ctr), 1);
        // straight line to END_ADDR
        for (int i = 0; i < 300 && m_mode == 1; i++) plain();
        chk("end_pc", int'(prog_ctr), 128);
        chk("end_done", int'(done), 1);
        repeat (3) plain();
        chk("done_held", int'(done), 1);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("idle_pc", int'(prog_ctr), 0);
        chk("idle_done", int'(done), 0);
        // branches and wrap
        plain();
        repeat (20) plain();
        chk("pc_20", int'(prog_ctr), 20);
        drive(1'b1, 1'b0, 2'b11, 1'b1, 12'd0, 6'b111100, 1'b0, 1'b0, 1'b0);
        chk("rel_back", int'(prog_ctr), 16);
        repeat (4) plain();
        drive(1'b1, 1'b0, 2'b11, 1'b0, 12'd0, 6'b111100, 1'b0, 1'b0, 1'b0);
        chk("rel_not_taken", int'(prog_ctr), 21);
        drive(1'b1, 1'b0, 2'b10, 1'b1, 12'd100, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("cond_abs", int'(prog_ctr), 100);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 12'd4095, 6'd0, 1'b0, 1'b0, 1'b0);
        plain();
        chk("wrap", int'(prog_ctr), 0);
        // nested calls, overflow and underflow
        drive(1'b1, 1'b0, 2'b01, 1'b0, 12'd10, 6'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd30, 6'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd50, 6'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd70, 6'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd90, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("no_overflow_yet", int'(stk_err), 0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd200, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("overflow_pc", int'(prog_ctr), 200);
        chk("overflow_err", int'(stk_err), 1);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("ret_71", int'(prog_ctr), 71);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("ret_51", int'(prog_ctr), 51);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("ret_31", int'(prog_ctr), 31);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("ret_11", int'(prog_ctr), 11);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("underflow_pc", int'(prog_ctr), 12);
        chk("underflow_err", int'(stk_err), 1);
        // stall freezes everything including a pending branch
        repeat (3) begin
            drive(1'b1, 1'b1, 2'b01, 1'b0, 12'd55, 6'd0, 1'b0, 1'b0, 1'b0);
            chk("stall_hold", int'(prog_ctr), 12);
        end
        drive(1'b1, 1'b0, 2'b01, 1'b0, 12'd55, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("after_stall", int'(prog_ctr), 55);
        // call+ret together: ret wins, then halt
        drive(1'b1, 1'b0, 2'b01, 1'b0, 12'd41, 6'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd9, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("call_to_9", int'(prog_ctr), 9);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd300, 6'd0, 1'b1, 1'b1, 1'b0);
        chk("call_ret_pc", int'(prog_ctr), 42);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        chk("halt_pc", int'(prog_ctr), 42);
        chk("halt_done", int'(done), 1);
        chk("halt_running", int'(running), 0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 12'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0 ? 2'($urandom_range(1, 3)) : 2'b00,
                  1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)), 6'($urandom),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 63) == 0);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
